// File: rtl/io_irq_if.sv
// Bus between the CPU/device side and the interrupt controller.
// The master drives device flags and CPU strobes; the slave returns status and the interrupt state.
interface io_irq_if;
  logic       in_flag;
  logic       in_flag_reset;
  logic       cpu_inp;
  logic       out_write;
  logic       out_done;
  logic       ion;
  logic       iof;
  logic       fetch_boundary;
  logic       fgi;
  logic       fgo;
  logic       ien;
  logic       irq;
  logic       int_cycle;
  logic [1:0] int_step;
  logic       int_src;

  modport master (
    output in_flag, cpu_inp, out_write, out_done, ion, iof, fetch_boundary,
    input  in_flag_reset, fgi, fgo, ien, irq, int_cycle, int_step, int_src
  );

  modport slave (
    input  in_flag, cpu_inp, out_write, out_done, ion, iof, fetch_boundary,
    output in_flag_reset, fgi, fgo, ien, irq, int_cycle, int_step, int_src
  );
endinterface

// File: rtl/io_interrupt_ctrl.sv
// I/O flag and interrupt controller: tracks FGI/FGO/IEN, raises R and runs
// the three-step interrupt cycle (RT0..RT2) at the next instruction fetch.
module io_interrupt_ctrl (
  input  logic  clk,
  input  logic  rst,
  io_irq_if.slave bus
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_PEND   = 2'd1;
  localparam logic [1:0] ST_INTCYC = 2'd2;

  logic [1:0] state_q, state_d;
  logic [1:0] step_q,  step_d;
  logic       fgi_q,   fgi_d;
  logic       fgo_q,   fgo_d;
  logic       ien_q,   ien_d;
  logic       src_q,   src_d;
  logic       ifr_q,   ifr_d;
  logic       req_ok;

  assign req_ok = ien_q & (fgi_q | fgo_q);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    src_d   = src_q;

    // The external flag is still 1 while its clear pulse is in flight; mask it off.
    fgi_d = bus.in_flag & ~bus.cpu_inp;
    ifr_d = bus.cpu_inp;

    fgo_d = fgo_q;
    if (bus.out_write)     fgo_d = 1'b0;
    else if (bus.out_done) fgo_d = 1'b1;

    ien_d = ien_q;
    if (bus.iof)      ien_d = 1'b0;
    else if (bus.ion) ien_d = 1'b1;

    case (state_q)
      ST_RUN: begin
        if (req_ok) state_d = ST_PEND;
      end
      ST_PEND: begin
        if (!req_ok) begin
          state_d = ST_RUN;
        end else if (bus.fetch_boundary) begin
          state_d = ST_INTCYC;
          step_d  = 2'd0;
          src_d   = ~fgi_q;
          ien_d   = 1'b0;
        end
      end
      ST_INTCYC: begin
        // ION/IOF have no effect while the interrupt cycle runs.
        ien_d = ien_q;
        if (step_q == 2'd2) begin
          state_d = ST_RUN;
          step_d  = 2'd0;
        end else begin
          step_d = step_q + 2'd1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      step_q  <= 2'd0;
      fgi_q   <= 1'b0;
      fgo_q   <= 1'b1;
      ien_q   <= 1'b0;
      src_q   <= 1'b0;
      ifr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      fgi_q   <= fgi_d;
      fgo_q   <= fgo_d;
      ien_q   <= ien_d;
      src_q   <= src_d;
      ifr_q   <= ifr_d;
    end
  end

  assign bus.fgi           = fgi_q;
  assign bus.fgo           = fgo_q;
  assign bus.ien           = ien_q;
  assign bus.irq           = (state_q != ST_RUN);
  assign bus.int_cycle     = (state_q == ST_INTCYC);
  assign bus.int_step      = step_q;
  assign bus.int_src       = src_q;
  assign bus.in_flag_reset = ifr_q;

endmodule
